// File: rtl/otp_pad_gen.sv
// One-time-pad word source: 32-bit right-shift Galois LFSR advanced 32 steps per
// accepted transfer, seeded by software and capped at MAX_WORDS words per seed.
module otp_pad_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] POLY      = 32'h80200003,
  parameter logic [15:0]      MAX_WORDS = 16'd1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             pad_ready,
  output logic             pad_valid,
  output logic [WIDTH-1:0] pad,
  output logic [15:0]      pad_count,
  output logic             pad_done,
  output logic             seed_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t state;

  // Fully unrolled: one pad word per transfer needs WIDTH LFSR steps in one cycle.
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pad       <= '0;
      pad_count <= '0;
      pad_valid <= 1'b0;
      pad_done  <= 1'b0;
      seed_err  <= 1'b0;
    end else if (seed_load) begin
      // A reseed wins in every state; a zero seed would lock the LFSR at zero.
      if (seed != '0) begin
        state     <= RUN;
        pad       <= seed;
        pad_count <= '0;
        pad_valid <= 1'b1;
        pad_done  <= 1'b0;
        seed_err  <= 1'b0;
      end else begin
        state     <= ERR;
        pad_valid <= 1'b0;
        pad_done  <= 1'b0;
        seed_err  <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (pad_ready) begin
            pad       <= adv(pad);
            pad_count <= pad_count + 16'd1;
            if (pad_count + 16'd1 == MAX_WORDS) begin
              state     <= DONE;
              pad_valid <= 1'b0;
              pad_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_pad_gen.sv
// Scoreboard bench for otp_pad_gen: two instances (default cap and a cap of 4) share
// stimulus; a spec-level model predicts each consumed pad word and the status flags.
module tb_otp_pad_gen;

  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [31:0] MSG  = 32'h74657374;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        pad_ready = 1'b0;

  logic        vld   [2];
  logic        done  [2];
  logic        err   [2];
  logic [31:0] pad_o [2];
  logic [15:0] cnt_o [2];

  otp_pad_gen #(.WIDTH(32), .POLY(POLY), .MAX_WORDS(16'd1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .pad_ready(pad_ready),
    .pad_valid(vld[0]), .pad(pad_o[0]), .pad_count(cnt_o[0]), .pad_done(done[0]),
    .seed_err(err[0])
  );

  otp_pad_gen #(.WIDTH(32), .POLY(POLY), .MAX_WORDS(16'd4)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .pad_ready(pad_ready),
    .pad_valid(vld[1]), .pad(pad_o[1]), .pad_count(cnt_o[1]), .pad_done(done[1]),
    .seed_err(err[1])
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic [47:0] q_a[$];
  logic [47:0] q_b[$];

  logic        m_valid [2];
  logic        m_done  [2];
  logic        m_err   [2];
  logic [31:0] m_pad   [2];
  int unsigned m_cnt   [2];

  function automatic int unsigned maxw(input int i);
    return (i == 0) ? 1024 : 4;
  endfunction

  function automatic logic [31:0] adv_ref(input logic [31:0] s);
    logic [31:0] r;
    logic        lsb;
    r = s;
    for (int k = 0; k < 32; k++) begin
      lsb = r[0];
      r   = r >> 1;
      if (lsb) r = r ^ POLY;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_err[i]   = 1'b0;
      m_pad[i]   = '0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("pad_valid", i, {31'b0, vld[i]},  {31'b0, m_valid[i]});
      chk("pad_done",  i, {31'b0, done[i]}, {31'b0, m_done[i]});
      chk("seed_err",  i, {31'b0, err[i]},  {31'b0, m_err[i]});
      chk("pad_count", i, {16'b0, cnt_o[i]}, m_cnt[i]);
      chk("pad",       i, pad_o[i], m_pad[i]);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, predict, check at next falling edge.
  task automatic step(input logic sl, input logic [31:0] sd, input logic rdy);
    #1;
    seed_load = sl;
    seed      = sd;
    pad_ready = rdy;
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && rdy) begin
        if (i == 0) q_a.push_back({m_cnt[i][15:0], m_pad[i]});
        else        q_b.push_back({m_cnt[i][15:0], m_pad[i]});
      end
      if (sl) begin
        if (sd != 0) begin
          m_valid[i] = 1'b1;
          m_done[i]  = 1'b0;
          m_err[i]   = 1'b0;
          m_pad[i]   = sd;
          m_cnt[i]   = 0;
        end else begin
          m_valid[i] = 1'b0;
          m_done[i]  = 1'b0;
          m_err[i]   = 1'b1;
        end
      end else if (m_valid[i] && rdy) begin
        m_pad[i] = adv_ref(m_pad[i]);
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == maxw(i)) begin
          m_valid[i] = 1'b0;
          m_done[i]  = 1'b1;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  // Monitor: every consumed word must match the next predicted one.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (vld[i] && pad_ready) begin
            if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
              tests++;
              failed++;
              $display("FAIL unexpected_xfer[%0d] @%0t: got pad %h expected no transfer",
                       i, $time, pad_o[i]);
            end else begin
              e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
              chk("xfer_pad",   i, pad_o[i], e[31:0]);
              chk("xfer_count", i, {16'b0, cnt_o[i]}, {16'b0, e[47:32]});
              chk("xor_recover", i, (MSG ^ pad_o[i]) ^ e[31:0], MSG);
            end
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Seed 1, first pad word then one transfer.
    step(1'b1, 32'h00000001, 1'b0);
    step(1'b0, '0, 1'b1);

    // Stall holds the word, then 8 back-to-back transfers (cap-4 instance exhausts).
    step(1'b1, 32'hACE12468, 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1);

    // Reseed clears pad_done; reseed with a simultaneous transfer is not counted.
    step(1'b1, $urandom | 32'h1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0BADF00D, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Zero seed in RUN goes to ERR, a good seed recovers.
    step(1'b1, 32'h00000002, 1'b0);
    step(1'b1, 32'h00000000, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h00000000, 1'b0);
    step(1'b1, 32'h00000001, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);

    // Asynchronous reset between edges while running.
    #1;
    seed_load = 1'b0;
    pad_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic        sl;
      logic [31:0] sd;
      sl = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(sl, sd, ($urandom_range(0, 3) != 0));
    end

    step(1'b0, '0, 1'b0);
    chk("queue_empty", 0, q_a.size(), 0);
    chk("queue_empty", 1, q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
